mag_peak_detect: RTL and testbench

Frame-based peak detector for the squared-magnitude stream produced by the I/Q magnitude stage of the GPR receive chain. It consumes one magnitude-squared sample per valid cycle, tracks the largest value and its sample index within each frame (delimited by `tlast`), and emits one registered result per frame. Each result carries the frame's `tuser`, the frame length, a threshold verdict and the OR of the upstream overflow flags. The block sits between the magnitude estimator and the host/DMA result path; its output side uses a valid/ready handshake.

---
 rtl/mag_peak_pkg.sv | 18 +
 rtl/mag_peak_hold.sv | 53 +++++
 rtl/mag_peak_detect.sv | 155 +++++++++++++++
 tb/tb_mag_peak_detect.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_peak_pkg.sv
// Shared types for the frame peak detector: accumulator state encoding and
// the result flag record. The full result record is width-dependent and lives in the top.
package mag_peak_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic peak_found;
    logic overflow;
    logic len_sat;
  } flags_t;

  localparam int unsigned FLAGS_LEN = $bits(flags_t);

endpackage

// File: rtl/mag_peak_hold.sv
// Result holding register: holds one result under valid/ready, overwrites on a
// new load and flags the overwrite of an unconsumed result with a one-cycle pulse.
module mag_peak_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         dropped
);

  logic         valid_q, valid_d;
  logic         dropped_q, dropped_d;
  logic [W-1:0] data_q, data_d;

  // next-state for the holding register
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    dropped_d = 1'b0;
    if (load) begin
      valid_d   = 1'b1;
      data_d    = load_data;
      dropped_d = valid_q & ~ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // holding register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= {W{1'b0}};
      dropped_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
    end
  end

  assign valid   = valid_q;
  assign data    = data_q;
  assign dropped = dropped_q;

endmodule

// File: rtl/mag_peak_detect.sv
// Frame peak detector: tracks max magnitude-squared and its first index per
// tlast-delimited frame, and hands one registered result per frame to the holder.
module mag_peak_detect
  import mag_peak_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned TUSER_LEN = 32,
  parameter int unsigned INDEX_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_LEN-1:0]  mag_data,
  input  logic                 mag_tvalid,
  input  logic                 mag_tlast,
  input  logic [TUSER_LEN-1:0] mag_tuser,
  input  logic                 mag_overflow,
  input  logic [DATA_LEN-1:0]  threshold,
  output logic [DATA_LEN-1:0]  peak_value,
  output logic [INDEX_LEN-1:0] peak_index,
  output logic [INDEX_LEN-1:0] frame_len,
  output logic [TUSER_LEN-1:0] frame_tuser,
  output logic                 peak_found,
  output logic                 frame_overflow,
  output logic                 len_sat,
  output logic                 result_tvalid,
  input  logic                 result_tready,
  output logic                 result_dropped
);

  typedef struct packed {
    logic [DATA_LEN-1:0]  value;
    logic [INDEX_LEN-1:0] index;
    logic [INDEX_LEN-1:0] len;
    logic [TUSER_LEN-1:0] tuser;
    flags_t               flags;
  } result_t;

  localparam int unsigned          RES_LEN = $bits(result_t);
  localparam logic [INDEX_LEN-1:0] CNT_MAX = {INDEX_LEN{1'b1}};
  localparam logic [INDEX_LEN-1:0] CNT_ONE = INDEX_LEN'(1'b1);

  state_e               state_q, state_d;
  logic [DATA_LEN-1:0]  max_q, max_d;
  logic [DATA_LEN-1:0]  thr_q, thr_d;
  logic [INDEX_LEN-1:0] idx_q, idx_d;
  logic [INDEX_LEN-1:0] cnt_q, cnt_d;
  logic [TUSER_LEN-1:0] tuser_q, tuser_d;
  logic                 ovf_q, ovf_d;
  logic                 sat_q, sat_d;
  logic                 finish_s;
  result_t              res_s;
  result_t              res_out_s;

  // accumulator next-state; the result is built from the *_d values so it includes the tlast sample
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    thr_d    = thr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tuser_d  = tuser_q;
    ovf_d    = ovf_q;
    sat_d    = sat_q;
    finish_s = 1'b0;
    if (mag_tvalid) begin
      case (state_q)
        ST_IDLE: begin
          max_d   = mag_data;
          idx_d   = {INDEX_LEN{1'b0}};
          cnt_d   = CNT_ONE;
          tuser_d = mag_tuser;
          thr_d   = threshold;
          ovf_d   = mag_overflow;
          sat_d   = 1'b0;
        end
        ST_ACCUM: begin
          // cnt_q is this sample's index; once saturated it also clamps max_idx
          if (mag_data > max_q) begin
            max_d = mag_data;
            idx_d = cnt_q;
          end else begin
            max_d = max_q;
            idx_d = idx_q;
          end
          if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          ovf_d = ovf_q | mag_overflow;
        end
        default: begin
          max_d = max_q;
        end
      endcase
      finish_s = mag_tlast;
      state_d  = mag_tlast ? ST_IDLE : ST_ACCUM;
    end else begin
      finish_s = 1'b0;
    end
  end

  assign res_s.value            = max_d;
  assign res_s.index            = idx_d;
  assign res_s.len              = cnt_d;
  assign res_s.tuser            = tuser_d;
  assign res_s.flags.peak_found = (max_d > thr_d);
  assign res_s.flags.overflow   = ovf_d;
  assign res_s.flags.len_sat    = sat_d;

  // accumulator flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      max_q   <= {DATA_LEN{1'b0}};
      thr_q   <= {DATA_LEN{1'b0}};
      idx_q   <= {INDEX_LEN{1'b0}};
      cnt_q   <= {INDEX_LEN{1'b0}};
      tuser_q <= {TUSER_LEN{1'b0}};
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      thr_q   <= thr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tuser_q <= tuser_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  mag_peak_hold #(
    .W (RES_LEN)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (finish_s),
    .load_data (res_s),
    .ready     (result_tready),
    .valid     (result_tvalid),
    .data      (res_out_s),
    .dropped   (result_dropped)
  );

  assign peak_value     = res_out_s.value;
  assign peak_index     = res_out_s.index;
  assign frame_len      = res_out_s.len;
  assign frame_tuser    = res_out_s.tuser;
  assign peak_found     = res_out_s.flags.peak_found;
  assign frame_overflow = res_out_s.flags.overflow;
  assign len_sat        = res_out_s.flags.len_sat;

endmodule

// File: tb/tb_mag_peak_detect.sv
// Bench for mag_peak_detect: two instances (INDEX_LEN 16 and 4) on shared stimulus,
// checked against a queue-based frame model and a valid/ready holding model.
module tb_mag_peak_detect;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [63:0] mag_data = 64'd0;
  logic        mag_tvalid = 1'b0;
  logic        mag_tlast = 1'b0;
  logic [31:0] mag_tuser = 32'd0;
  logic        mag_overflow = 1'b0;
  logic [63:0] threshold = 64'd0;
  logic        result_tready = 1'b0;

  logic [63:0] a_val, b_val;
  logic [15:0] a_idx, a_len;
  logic [3:0]  b_idx, b_len;
  logic [31:0] a_tuser, b_tuser;
  logic        a_found, a_ovf, a_sat, a_tvalid, a_drop;
  logic        b_found, b_ovf, b_sat, b_tvalid, b_drop;

  mag_peak_detect #(.DATA_LEN(64), .TUSER_LEN(32), .INDEX_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .mag_data(mag_data), .mag_tvalid(mag_tvalid), .mag_tlast(mag_tlast),
    .mag_tuser(mag_tuser), .mag_overflow(mag_overflow), .threshold(threshold),
    .peak_value(a_val), .peak_index(a_idx), .frame_len(a_len), .frame_tuser(a_tuser),
    .peak_found(a_found), .frame_overflow(a_ovf), .len_sat(a_sat),
    .result_tvalid(a_tvalid), .result_tready(result_tready), .result_dropped(a_drop));

  mag_peak_detect #(.DATA_LEN(64), .TUSER_LEN(32), .INDEX_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .mag_data(mag_data), .mag_tvalid(mag_tvalid), .mag_tlast(mag_tlast),
    .mag_tuser(mag_tuser), .mag_overflow(mag_overflow), .threshold(threshold),
    .peak_value(b_val), .peak_index(b_idx), .frame_len(b_len), .frame_tuser(b_tuser),
    .peak_found(b_found), .frame_overflow(b_ovf), .len_sat(b_sat),
    .result_tvalid(b_tvalid), .result_tready(result_tready), .result_dropped(b_drop));

  logic [130:0] act_a;
  logic [106:0] act_b;
  assign act_a = {a_val, a_idx, a_len, a_tuser, a_found, a_ovf, a_sat};
  assign act_b = {b_val, b_idx, b_len, b_tuser, b_found, b_ovf, b_sat};

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  q_val[$];
  logic         q_ovf[$];
  logic [31:0]  f_tuser;
  logic [63:0]  f_thr;
  logic [130:0] exp_a;
  logic [106:0] exp_b;
  logic         completed;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame model: max over the frame, first index of it, length, all clamped to the counter range
  task automatic build_expected();
    logic [63:0] e_val;
    logic        e_ovf;
    int          e_first;
    int          n;
    e_val = 64'd0; e_ovf = 1'b0; e_first = 0; n = q_val.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0 || q_val[i] > e_val) begin
        e_val   = q_val[i];
        e_first = i;
      end
      e_ovf = e_ovf | q_ovf[i];
    end
    exp_a = {e_val, 16'(e_first < 65535 ? e_first : 65535), 16'(n < 65535 ? n : 65535),
             f_tuser, (e_val > f_thr), e_ovf, (n > 65535)};
    exp_b = {e_val, 4'(e_first < 15 ? e_first : 15), 4'(n < 15 ? n : 15),
             f_tuser, (e_val > f_thr), e_ovf, (n > 15)};
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic o,
                       input logic [31:0] tu, input logic [63:0] th);
    mag_tvalid = v; mag_data = d; mag_tlast = l; mag_overflow = o; mag_tuser = tu; threshold = th;
    if (v) begin
      if (q_val.size() == 0) begin
        f_tuser = tu;
        f_thr   = th;
      end
      q_val.push_back(d);
      q_ovf.push_back(o);
    end
    completed = v && l;
    if (completed) begin
      build_expected();
      q_val.delete();
      q_ovf.delete();
    end
    step();
    mag_tvalid = 1'b0;
    mag_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({act_a, a_tvalid, a_drop, act_b, b_tvalid, b_drop} !== {131'd0, 2'b00, 107'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h vld=%b%b expected all zero", act_a, act_b, a_tvalid, b_tvalid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    result_tready = 1'b1;
    drive(1'b1, 64'd5, 1'b0, 1'b0, 32'hA5, 64'd8);
    drive(1'b1, 64'd9, 1'b0, 1'b0, 32'h11, 64'd0);
    drive(1'b1, 64'd3, 1'b0, 1'b0, 32'h22, 64'd0);
    drive(1'b1, 64'd9, 1'b0, 1'b0, 32'h33, 64'd0);
    drive(1'b1, 64'd1, 1'b1, 1'b0, 32'h44, 64'd0);
    n_tests++;
    if ({a_val, a_idx, a_len, a_tuser, a_found, a_tvalid} !== {64'd9, 16'd1, 16'd5, 32'hA5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_fields: got val=%0d idx=%0d len=%0d tuser=%h found=%b vld=%b expected 9 1 5 a5 1 1",
               a_val, a_idx, a_len, a_tuser, a_found, a_tvalid);
    end
    n_tests++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL basic_small: got %h expected %h", act_b, exp_b);
    end
    step();
    n_tests++;
    if ({a_tvalid, b_tvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_consumed: got tvalid=%b%b expected 00", a_tvalid, b_tvalid);
    end
  endtask

  task automatic test_single();
    result_tready = 1'b1;
    drive(1'b1, 64'd7, 1'b1, 1'b0, 32'h5, 64'd7);
    n_tests++;
    if ({a_idx, a_len, a_found, a_tvalid} !== {16'd0, 16'd1, 1'b0, 1'b1} || act_a !== exp_a) begin
      n_fail++;
      $display("FAIL single_sample: got %h expected %h", act_a, exp_a);
    end
  endtask

  task automatic test_gaps();
    result_tready = 1'b1;
    drive(1'b1, 64'd2, 1'b0, 1'b0, 32'h77, 64'd0);
    drive(1'b0, 64'd99, 1'b1, 1'b1, 32'h0, 64'd0);
    drive(1'b0, 64'd99, 1'b0, 1'b1, 32'h0, 64'd0);
    n_tests++;
    if ({a_tvalid, a_drop} !== 2'b00) begin
      n_fail++;
      $display("FAIL gaps_no_result: got tvalid=%b drop=%b expected 0 0", a_tvalid, a_drop);
    end
    drive(1'b1, 64'd8, 1'b0, 1'b0, 32'h0, 64'd0);
    drive(1'b1, 64'd4, 1'b1, 1'b1, 32'h0, 64'd0);
    n_tests++;
    if ({a_val, a_idx, a_len, a_ovf} !== {64'd8, 16'd1, 16'd3, 1'b1} || act_a !== exp_a || act_b !== exp_b) begin
      n_fail++;
      $display("FAIL gaps_result: got %h expected %h", act_a, exp_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [130:0] held;
    result_tready = 1'b1;
    step();
    result_tready = 1'b0;
    drive(1'b1, 64'd3, 1'b0, 1'b0, 32'h1, 64'd2);
    drive(1'b1, 64'd1, 1'b0, 1'b0, 32'h0, 64'd0);
    drive(1'b1, 64'd2, 1'b1, 1'b0, 32'h0, 64'd0);
    n_tests++;
    if ({a_tvalid, a_drop} !== 2'b10 || act_a !== exp_a) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b drop=%b %h expected 1 0 %h", a_tvalid, a_drop, act_a, exp_a);
    end
    drive(1'b1, 64'd4, 1'b0, 1'b0, 32'h2, 64'd9);
    drive(1'b1, 64'd6, 1'b0, 1'b1, 32'h0, 64'd0);
    drive(1'b1, 64'd5, 1'b1, 1'b0, 32'h0, 64'd0);
    n_tests++;
    if ({a_tvalid, a_drop, b_drop} !== 3'b111 || act_a !== exp_a) begin
      n_fail++;
      $display("FAIL b2b_drop: got vld=%b drop=%b%b %h expected 1 11 %h", a_tvalid, a_drop, b_drop, act_a, exp_a);
    end
    held = exp_a;
    step();
    n_tests++;
    if ({a_tvalid, a_drop} !== 2'b10 || act_a !== held) begin
      n_fail++;
      $display("FAIL b2b_hold: got vld=%b drop=%b %h expected 1 0 %h", a_tvalid, a_drop, act_a, held);
    end
    result_tready = 1'b1;
    step();
    n_tests++;
    if ({a_tvalid, b_tvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_release: got tvalid=%b%b expected 00", a_tvalid, b_tvalid);
    end
  endtask

  task automatic test_saturation();
    result_tready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 64'(i), (i == 20), 1'b0, 32'h7, 64'd0);
    end
    n_tests++;
    if ({b_val, b_idx, b_len, b_sat} !== {64'd20, 4'd15, 4'd15, 1'b1} || act_b !== exp_b) begin
      n_fail++;
      $display("FAIL sat_small: got %h expected %h", act_b, exp_b);
    end
    n_tests++;
    if ({a_idx, a_len, a_sat} !== {16'd19, 16'd20, 1'b0} || act_a !== exp_a) begin
      n_fail++;
      $display("FAIL sat_wide: got %h expected %h", act_a, exp_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    result_tready = 1'b0;
    drive(1'b1, 64'd10, 1'b1, 1'b0, 32'h3, 64'd0);
    drive(1'b1, 64'd100, 1'b0, 1'b1, 32'h9, 64'd0);
    drive(1'b1, 64'd200, 1'b0, 1'b1, 32'h0, 64'd0);
    rst = 1'b1;
    q_val.delete();
    q_ovf.delete();
    step();
    rst = 1'b0;
    n_tests++;
    if ({act_a, a_tvalid, a_drop, b_tvalid, b_drop} !== {131'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got %h vld=%b drop=%b expected zero", act_a, a_tvalid, a_drop);
    end
    result_tready = 1'b1;
    drive(1'b1, 64'd3, 1'b0, 1'b0, 32'h4, 64'd1);
    drive(1'b1, 64'd4, 1'b1, 1'b0, 32'h0, 64'd0);
    n_tests++;
    if ({a_val, a_len, a_ovf, a_tuser} !== {64'd4, 16'd2, 1'b0, 32'h4} || act_a !== exp_a || a_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_result: got %h expected %h", act_a, exp_a);
    end
  endtask

  task automatic test_random();
    logic         m_valid, m_drop, gap, rdy;
    logic [130:0] m_a;
    logic [106:0] m_b;
    logic [63:0]  v;
    int           len, sent;
    rst = 1'b1;
    q_val.delete();
    q_ovf.delete();
    step();
    rst = 1'b0;
    m_valid = 1'b0;
    m_a = 131'd0;
    m_b = 107'd0;
    for (int f = 0; f < 40; f++) begin
      len  = $urandom_range(1, 24);
      sent = 0;
      while (sent < len) begin
        gap = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        result_tready = rdy;
        v = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 12));
        if (gap) begin
          drive(1'b0, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 64'($urandom_range(0, 12)));
        end else begin
          drive(1'b1, v, (sent == len - 1), ($urandom_range(0, 9) == 0), $urandom, 64'($urandom_range(0, 12)));
          sent++;
        end
        m_drop = completed && m_valid && !rdy;
        if (completed) begin
          m_valid = 1'b1;
          m_a = exp_a;
          m_b = exp_b;
        end else if (m_valid && rdy) begin
          m_valid = 1'b0;
        end
        n_tests++;
        if (a_tvalid !== m_valid || a_drop !== m_drop || (m_valid && act_a !== m_a)) begin
          n_fail++;
          $display("FAIL rand_a f%0d: got vld=%b drop=%b %h expected %b %b %h", f, a_tvalid, a_drop, act_a, m_valid, m_drop, m_a);
        end
        n_tests++;
        if (b_tvalid !== m_valid || b_drop !== m_drop || (m_valid && act_b !== m_b)) begin
          n_fail++;
          $display("FAIL rand_b f%0d: got vld=%b drop=%b %h expected %b %b %h", f, b_tvalid, b_drop, act_b, m_valid, m_drop, m_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_gaps();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
